// File: rtl/mem_bus_arbiter_pkg.sv
// State encoding and access-size codes shared by the memory bus arbiter and its bench.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like bus between fetch and load/store ports, one transaction in flight.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    state_t state;
    logic   pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = inst, 1 = data

    assign pick_data = data_req && (!inst_req || !last_grant);
`else
    // MEM is older than IF, so data must win a tie to avoid deadlock.
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_data) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        busy      <= 1'b1;
                        state     <= ST_D_ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b1;
`endif
                    end else if (inst_req) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_size  <= SZ_WORD;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                        busy      <= 1'b1;
                        state     <= ST_I_ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b0;
`endif
                    end
                end
                ST_I_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= ST_I_DATA;
                    end
                end
                ST_D_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= ST_D_DATA;
                    end
                end
                ST_I_DATA, ST_D_DATA: begin
                    if (bus_data_ok) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshakes reach only the current owner; a stray bus_data_ok elsewhere is dropped.
    assign inst_addr_ok = (state == ST_I_ADDR) && bus_addr_ok && inst_req;
    assign data_addr_ok = (state == ST_D_ADDR) && bus_addr_ok && data_req;
    assign inst_data_ok = (state == ST_I_DATA) && bus_data_ok;
    assign data_data_ok = (state == ST_D_DATA) && bus_data_ok;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scripted downstream bus with a response scoreboard.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_iaok = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every data_ok must match the next expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_addr_ok) n_iaok++;
            if (inst_data_ok || data_data_ok) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'(inst_data_ok) + 32'(data_data_ok), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_port_data", 32'(data_data_ok), 32'(e.is_d));
                    chk("sb_port_inst", 32'(inst_data_ok), 32'(!e.is_d));
                    chk("sb_rdata", e.is_d ? data_rdata : inst_rdata, e.rd);
                end
            end
        end
    end

    task automatic chk_fields(input string tag, input logic [31:0] a, input logic w,
                              input logic [1:0] s, input logic [31:0] wd);
        chk({tag, "_bus_req"},   32'(bus_req), 32'd1);
        chk({tag, "_bus_addr"},  bus_addr, a);
        chk({tag, "_bus_wr"},    32'(bus_wr), 32'(w));
        chk({tag, "_bus_size"},  32'(bus_size), 32'(s));
        chk({tag, "_bus_wdata"}, bus_wdata, wd);
    endtask

    // Entered at a negedge with bus_req already high for this transaction.
    task automatic serve(input string tag, input logic is_d, input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic [31:0] wd,
                         input int aw, input int dw, input logic [31:0] rd);
        chk_fields(tag, a, w, s, wd);
        for (int i = 0; i < aw; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_fields({tag, "_hold"}, a, w, s, wd);
            chk({tag, "_hold_aok"}, 32'(inst_addr_ok) + 32'(data_addr_ok), 32'd0);
        end
        @(posedge clk); #1;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        chk({tag, "_win_aok"},  32'(is_d ? data_addr_ok : inst_addr_ok), 32'd1);
        chk({tag, "_lose_aok"}, 32'(is_d ? inst_addr_ok : data_addr_ok), 32'd0);
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        if (is_d) data_req = 1'b0; else inst_req = 1'b0;
        @(negedge clk);
        chk({tag, "_data_bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_data_busy"},    32'(busy), 32'd1);
        for (int i = 1; i < dw; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        @(negedge clk);
        chk({tag, "_win_dok"},  32'(is_d ? data_data_ok : inst_data_ok), 32'd1);
        chk({tag, "_lose_dok"}, 32'(is_d ? inst_data_ok : data_data_ok), 32'd0);
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_bubble_req"},  32'(bus_req), 32'd0);
        chk({tag, "_bubble_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req",   32'(bus_req), 32'd0);
        chk("rst_bus_wr",    32'(bus_wr), 32'd0);
        chk("rst_bus_size",  32'(bus_size), 32'd0);
        chk("rst_bus_addr",  bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_oks", 32'(inst_addr_ok) + 32'(data_addr_ok) + 32'(inst_data_ok) + 32'(data_data_ok), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'h1234_5678);
        chk("rst_data_rdata", data_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // Fetch only
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        sb.push_back('{is_d: 1'b0, rd: 32'h2408_0001});
        @(negedge clk);
        chk("t1_latency_req_low", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        serve("t1", 1'b0, 32'hBFC0_0000, 1'b0, SZ_WORD, 32'd0, 2, 3, 32'h2408_0001);
        chk("t1_iaok_pulses", 32'(n_iaok), 32'd1);

        // Tie: store vs fetch; data wins, fetch follows after one bubble
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_size = SZ_WORD;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        sb.push_back('{is_d: 1'b1, rd: 32'h0000_00A5});
        sb.push_back('{is_d: 1'b0, rd: 32'h3C1D_8000});
        @(negedge clk);
        @(negedge clk);
        serve("t2d", 1'b1, 32'h8000_0010, 1'b1, SZ_WORD, 32'hDEAD_BEEF, 5, 1, 32'h0000_00A5);
        @(negedge clk);
        serve("t2i", 1'b0, 32'hBFC0_0004, 1'b0, SZ_WORD, 32'd0, 0, 2, 32'h3C1D_8000);

        // Byte load
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b0; data_size = SZ_BYTE;
        data_addr = 32'h8000_0003; data_wdata = 32'hCAFE_0000;
        sb.push_back('{is_d: 1'b1, rd: 32'h0000_0077});
        @(negedge clk);
        @(negedge clk);
        serve("t3", 1'b1, 32'h8000_0003, 1'b0, SZ_BYTE, 32'hCAFE_0000, 1, 2, 32'h0000_0077);

        // Second tie, last grant was data
        @(posedge clk); #1;
        data_req = 1'b1; data_wr = 1'b1; data_size = SZ_HALF;
        data_addr = 32'h8000_0020; data_wdata = 32'h1122_3344;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sb.push_back('{is_d: 1'b0, rd: 32'h0000_1111});
        sb.push_back('{is_d: 1'b1, rd: 32'h0000_2222});
        @(negedge clk);
        @(negedge clk);
        serve("t4i", 1'b0, 32'hBFC0_0008, 1'b0, SZ_WORD, 32'd0, 1, 1, 32'h0000_1111);
        @(negedge clk);
        serve("t4d", 1'b1, 32'h8000_0020, 1'b1, SZ_HALF, 32'h1122_3344, 0, 1, 32'h0000_2222);
`else
        sb.push_back('{is_d: 1'b1, rd: 32'h0000_2222});
        sb.push_back('{is_d: 1'b0, rd: 32'h0000_1111});
        @(negedge clk);
        @(negedge clk);
        serve("t4d", 1'b1, 32'h8000_0020, 1'b1, SZ_HALF, 32'h1122_3344, 1, 1, 32'h0000_2222);
        @(negedge clk);
        serve("t4i", 1'b0, 32'hBFC0_0008, 1'b0, SZ_WORD, 32'd0, 0, 1, 32'h0000_1111);
`endif

        // Reset while in I_DATA; the later response must be dropped
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        @(negedge clk);
        @(negedge clk);
        chk("t5_bus_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("t5_idata_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_bus_req", 32'(bus_req), 32'd0);
        chk("t5_rst_busy",    32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_0001;
        @(negedge clk);
        chk("t5_no_inst_dok", 32'(inst_data_ok), 32'd0);
        @(posedge clk); #1;
        bus_data_ok = 1'b0;

        // Stray bus_data_ok while idle
        @(posedge clk); #1;
        bus_data_ok = 1'b1;
        @(negedge clk);
        chk("t6_no_dok", 32'(inst_data_ok) + 32'(data_data_ok), 32'd0);
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_busy",    32'(busy), 32'd0);
        chk("t6_bus_req", 32'(bus_req), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("iaok_total", 32'(n_iaok), 32'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
